fusion_mac_ctrl: RTL
====================

// Module: fusion_mac_ctrl
// PURPOSE
//   Sequencer around one fusion_unit. Takes a job config (precision mode, operand
//   signedness, vector length) and streams LEN operand pairs into the fusion_unit
//   over valid/ready. It accumulates the products into a wide accumulator and
//   returns the dot product over a valid/ready result port.
//   Sits between the operand buffers and the output writeback of a MAC tile.
// PARAMETERS
//   ACC_W   32  accumulator / result width (>=16)
//   LEN_W   8   width of job length field (max LEN = 2^LEN_W-1)
// PORTS
//   clk        in   1      single clock, rising edge
//   nrst       in   1      synchronous active-low reset
//   start      in   1      job start pulse; sampled only in IDLE
//   cfg_mode   in   2      fusion_unit precision mode, latched on accepted start
//   cfg_sx     in   1      x signed, latched on start
//   cfg_sy     in   1      y signed, latched on start
//   cfg_len    in   LEN_W  number of operand pairs, latched on start
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      controller accepts operand pair
//   in_x       in   8      operand x
//   in_y       in   8      operand y
//   res_valid  out  1      result valid
//   res_ready  in   1      result consumer ready
//   res_data   out  ACC_W  accumulated result
//   busy       out  1      high in any state except IDLE
// BEHAVIOUR
//   Reset (nrst=0 at an edge): state=IDLE. in_ready, res_valid, busy, acc/res_data,
//     count and op_v are all 0. Applies mid-job: the partial sum is discarded.
//   FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE:
//     IDLE: in_ready=0. start=1 latches cfg_*, clears acc and count.
//       cfg_len=0 goes to DONE; otherwise goes to RUN.
//     RUN: in_ready=1. A beat is in_valid&in_ready; it captures in_x/in_y into op_q
//       and sets op_v. count increments per beat. The beat with count==len-1 moves
//       the FSM to DRAIN. in_valid gaps stall RUN indefinitely.
//     DRAIN: in_ready=0. Lasts exactly 1 cycle while the last op_q accumulates,
//       then moves to DONE.
//     DONE: res_valid=1; res_data is held stable until res_ready=1, then IDLE.
//   Pipeline: fusion_unit is combinational on op_q plus the latched mode/sx/sy.
//     At every edge with op_v=1: acc <= acc + ext(product).
//     ext() sign-extends the 16-bit product if (sx|sy), else zero-extends.
//   Latency: last beat at edge T, acc final at T+1, res_valid=1 from T+1 to T+2.
//     Equivalently, res_valid is first seen in the cycle after DRAIN.
//   Arithmetic: acc wraps modulo 2^ACC_W; there is no saturation and no overflow flag.
//   start outside IDLE is ignored. in_valid outside RUN is ignored.
//   res_data = acc at all times; it is meaningful only while res_valid=1.
//   Config is frozen for the whole job; cfg_* changes mid-job have no effect.
//   Back-to-back jobs: start is accepted in the cycle after the DONE handshake
//     (minimum 1 IDLE cycle).
// STRUCTURE
//   Shared include fusion_pkg.vh: FSM state localparams (IDLE/RUN/DRAIN/DONE, 2b),
//     MODE_8X8=2'b00, MODE_4X4=2'b01, MODE_2X2=2'b10, FU_PROD_W=16.
//   Sub-module: existing fusion_unit (x, y, sx, sy, mode -> 16b product), instantiated
//     once. FSM, counter, op_q register and accumulator live in this module.
// TESTING
//   1 Signed 8x8: mode=00, sx=sy=1, len=3, pairs (-12,-8), (-13,13), (-42,-61).
//     -> res_data=2489 (0x9B9); res_valid 2 edges after the 3rd beat.
//   2 Unsigned: sx=sy=0, len=2, pairs (255,255) x2 -> res_data=130050.
//     in_ready=0 after the 2nd beat.
//   3 len=0: start at edge T -> res_valid=1 after T+1 with res_data=0; no in_ready pulse.
//   4 Backpressure: len=3, in_valid toggled 1,0,0,1,0,1 and res_ready held 0 for
//     5 cycles -> same sum as with no stalls. res_data and res_valid stable while
//     stalled. A start pulse during DONE is ignored.
//   5 Reset mid-RUN: 1 of 3 beats done, pulse nrst=0 for 1 edge -> all outputs 0,
//     IDLE. Then start len=1, unsigned (3,5) -> res_data=15 (no residue).
//   6 Wrap: ACC_W=16, unsigned, len=2, (255,255) x2 -> res_data=130050 mod 65536=64514.

Source files
------------

// File: rtl/fusion_mac_ctrl_pkg.sv
// Shared types and constants for the fusion MAC controller slice.
//   state_e   : controller FSM states (IDLE -> RUN -> DRAIN -> DONE)
//   fu_mode_e : fusion_unit precision modes (8x8, dual 4x4, quad 2x2)
//   FU_PROD_W : width of the fusion_unit product
package fusion_mac_ctrl_pkg;

    localparam int FU_PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MODE_8X8  = 2'b00,
        MODE_4X4  = 2'b01,
        MODE_2X2  = 2'b10,
        MODE_RSVD = 2'b11
    } fu_mode_e;

endpackage

// File: rtl/fusion_mac_ctrl_if.sv
// Bus between the operand buffers / writeback and the MAC controller.
//   start, cfg_*           : job start pulse and job configuration
//   in_valid/in_ready/in_* : operand pair stream
//   res_valid/res_ready/res_data : result stream
//   busy, state_dbg        : status and FSM state for observation
// Handshake rule for both streams: a transfer happens at a rising clock edge
// where valid and ready are both 1; the producer holds its payload stable
// while valid=1 and ready=0, and ready never depends combinationally on valid.
interface fusion_mac_ctrl_if #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [1:0]       cfg_mode;
    logic             cfg_sx;
    logic             cfg_sy;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_x;
    logic [7:0]       in_y;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output start, cfg_mode, cfg_sx, cfg_sy, cfg_len,
        output in_valid, in_x, in_y, res_ready,
        input  in_ready, res_valid, res_data, busy, state_dbg
    );

    modport slave (
        input  start, cfg_mode, cfg_sx, cfg_sy, cfg_len,
        input  in_valid, in_x, in_y, res_ready,
        output in_ready, res_valid, res_data, busy, state_dbg
    );
endinterface

// File: rtl/fusion_mac_ctrl_fusion_unit.sv
// Combinational fusion multiplier.
//   x, y   : 8-bit operands
//   sx, sy : operand signedness (applies to every lane)
//   mode   : 8X8 one product; 4X4 sum of two nibble-lane products;
//            2X2 sum of four 2-bit-lane products; reserved mode gives 0
//   prod   : 16-bit product (two's complement when any operand is signed)
module fusion_mac_ctrl_fusion_unit
    import fusion_mac_ctrl_pkg::*;
(
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    input  logic                 sx,
    input  logic                 sy,
    input  fu_mode_e             mode,
    output logic [FU_PROD_W-1:0] prod
);

    // Lanes are extended to the full product width first; the low 16 bits of
    // a 16x16 product are correct for any mix of signed/unsigned operands.
    logic [FU_PROD_W-1:0] xl;
    logic [FU_PROD_W-1:0] yl;

    always_comb begin
        prod = '0;
        xl   = '0;
        yl   = '0;
        case (mode)
            MODE_8X8: begin
                xl   = {{8{sx & x[7]}}, x};
                yl   = {{8{sy & y[7]}}, y};
                prod = xl * yl;
            end
            MODE_4X4: begin
                for (int i = 0; i < 2; i++) begin
                    xl   = {{12{sx & x[4*i+3]}}, x[4*i +: 4]};
                    yl   = {{12{sy & y[4*i+3]}}, y[4*i +: 4]};
                    prod = prod + xl * yl;
                end
            end
            MODE_2X2: begin
                for (int i = 0; i < 4; i++) begin
                    xl   = {{14{sx & x[2*i+1]}}, x[2*i +: 2]};
                    yl   = {{14{sy & y[2*i+1]}}, y[2*i +: 2]};
                    prod = prod + xl * yl;
                end
            end
            default: prod = '0;
        endcase
    end

endmodule

// File: rtl/fusion_mac_ctrl.sv
// Job sequencer around one fusion_unit: latches a job config on start, accepts
// cfg_len operand pairs, accumulates their products and returns the dot product.
//   clk, nrst : clock, synchronous active-low reset
//   bus       : slave side of fusion_mac_ctrl_if (config, operand and result
//               streams, busy, state_dbg)
module fusion_mac_ctrl
    import fusion_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    fusion_mac_ctrl_if.slave  bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e               state_q, state_d;
    fu_mode_e             mode_q;
    logic                 sx_q, sy_q;
    logic [LEN_W-1:0]     len_q, count_q;
    logic [7:0]           op_x_q, op_y_q;
    logic                 op_v_q;
    logic [ACC_W-1:0]     acc_q;
    logic                 in_ready, res_valid, accept_start, beat;
    logic [FU_PROD_W-1:0] prod;
    logic [ACC_W-1:0]     prod_ext;

    fusion_mac_ctrl_fusion_unit u_fu (
        .x    (op_x_q),
        .y    (op_y_q),
        .sx   (sx_q),
        .sy   (sy_q),
        .mode (mode_q),
        .prod (prod)
    );

    // Any signed operand makes the product two's complement.
    assign prod_ext = (sx_q | sy_q) ? ACC_W'($signed(prod)) : ACC_W'(prod);

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        res_valid    = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    state_d      = (bus.cfg_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (bus.in_valid && (count_q == len_q - LEN_ONE)) state_d = ST_DRAIN;
            end
            // Single cycle in which the last captured pair is accumulated.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat = in_ready & bus.in_valid;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_8X8;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
            op_v_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_v_q  <= beat;
            if (beat) begin
                op_x_q  <= bus.in_x;
                op_y_q  <= bus.in_y;
                count_q <= count_q + LEN_ONE;
            end
            if (accept_start) begin
                mode_q  <= fu_mode_e'(bus.cfg_mode);
                sx_q    <= bus.cfg_sx;
                sy_q    <= bus.cfg_sy;
                len_q   <= bus.cfg_len;
                count_q <= '0;
                acc_q   <= '0;
            end else if (op_v_q) begin
                acc_q <= acc_q + prod_ext;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = acc_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.state_dbg = state_q;

endmodule
